// File: rtl/scr1_lsu_pkg.sv
//==============================================================================
// Module      : scr1_lsu_pkg
// Description : Shared types and helpers for the multi-outstanding LSU:
//               command/memory/exception enums, queue entry, misalign check
//               and load lane extraction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package scr1_lsu_pkg;

    localparam int unsigned SCR1_XLEN        = 32;
    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_LSU_OFFS_W  = 3;

    typedef enum logic [3:0] {
        SCR1_LSU_CMD_NONE = 4'd0,
        SCR1_LSU_CMD_LB   = 4'd1,
        SCR1_LSU_CMD_LH   = 4'd2,
        SCR1_LSU_CMD_LW   = 4'd3,
        SCR1_LSU_CMD_LBU  = 4'd4,
        SCR1_LSU_CMD_LHU  = 4'd5,
        SCR1_LSU_CMD_SB   = 4'd6,
        SCR1_LSU_CMD_SH   = 4'd7,
        SCR1_LSU_CMD_SW   = 4'd8
    } type_scr1_lsu_cmd_sel_e;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;

    typedef enum logic [3:0] {
        SCR1_EXC_CODE_INSTR_MISALIGN    = 4'd0,
        SCR1_EXC_CODE_INSTR_ACCESS_FAULT = 4'd1,
        SCR1_EXC_CODE_ILLEGAL_INSTR     = 4'd2,
        SCR1_EXC_CODE_BREAKPOINT        = 4'd3,
        SCR1_EXC_CODE_LD_ADDR_MISALIGN  = 4'd4,
        SCR1_EXC_CODE_LD_ACCESS_FAULT   = 4'd5,
        SCR1_EXC_CODE_ST_ADDR_MISALIGN  = 4'd6,
        SCR1_EXC_CODE_ST_ACCESS_FAULT   = 4'd7,
        SCR1_EXC_CODE_ECALL_U           = 4'd8,
        SCR1_EXC_CODE_ECALL_M           = 4'd11
    } type_scr1_exc_code_e;

    // Offset field is sized for the widest (64-bit) bus; narrower buses zero-extend.
    typedef struct packed {
        type_scr1_lsu_cmd_sel_e      cmd;
        logic [SCR1_LSU_OFFS_W-1:0]  offset;
    } type_scr1_lsu_q_entry_s;

    function automatic logic scr1_lsu_is_load(input type_scr1_lsu_cmd_sel_e cmd);
        logic res;
        case (cmd)
            SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LW,
            SCR1_LSU_CMD_LBU, SCR1_LSU_CMD_LHU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic scr1_lsu_is_store(input type_scr1_lsu_cmd_sel_e cmd);
        logic res;
        case (cmd)
            SCR1_LSU_CMD_SB, SCR1_LSU_CMD_SH, SCR1_LSU_CMD_SW: res = 1'b1;
            default:                                           res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic scr1_lsu_misalign(input type_scr1_lsu_cmd_sel_e cmd,
                                               input logic [1:0]             addr_lsb);
        logic res;
        case (cmd)
            SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH: res = addr_lsb[0];
            SCR1_LSU_CMD_LW, SCR1_LSU_CMD_SW:                   res = |addr_lsb;
            default:                                            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [SCR1_XLEN-1:0] scr1_lsu_ld_extract(
        input logic [63:0]                  rdata,
        input logic [SCR1_LSU_OFFS_W-1:0]   offset,
        input type_scr1_lsu_cmd_sel_e       cmd);
        logic [63:0]          shifted;
        logic [SCR1_XLEN-1:0] res;
        shifted = rdata >> {offset, 3'b000};
        case (cmd)
            SCR1_LSU_CMD_LB:  res = {{24{shifted[7]}}, shifted[7:0]};
            SCR1_LSU_CMD_LBU: res = {24'h0, shifted[7:0]};
            SCR1_LSU_CMD_LH:  res = {{16{shifted[15]}}, shifted[15:0]};
            SCR1_LSU_CMD_LHU: res = {16'h0, shifted[15:0]};
            SCR1_LSU_CMD_LW:  res = shifted[31:0];
            default:          res = '0;
        endcase
        return res;
    endfunction

endpackage : scr1_lsu_pkg

`default_nettype wire

// File: rtl/scr1_lsu_cmd_queue.sv
//==============================================================================
// Module      : scr1_lsu_cmd_queue
// Description : In-order FIFO tracking issued DMEM commands until their
//               response returns.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module scr1_lsu_cmd_queue
    import scr1_lsu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  type_scr1_lsu_q_entry_s push_data,
    input  logic                   pop,
    output type_scr1_lsu_q_entry_s head,
    output logic [CNT_W-1:0]       cnt,
    output logic                   full,
    output logic                   empty
);

    type_scr1_lsu_q_entry_s mem_q [DEPTH];
    type_scr1_lsu_q_entry_s mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   push_ok;
    logic                   pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule : scr1_lsu_cmd_queue

`default_nettype wire

// File: rtl/scr1_pipe_lsu_mo.sv
//==============================================================================
// Module      : scr1_pipe_lsu_mo
// Description : Load/store unit with up to OUTST_DEPTH in-order DMEM
//               transactions in flight. Optional response timeout enabled by
//               the SCR1_LSU_RESP_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module scr1_pipe_lsu_mo
    import scr1_lsu_pkg::*;
#(
    parameter int unsigned DMEM_DWIDTH  = 32,
    parameter int unsigned OUTST_DEPTH  = 2,
    parameter int unsigned RESP_TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          exu2lsu_req,
    input  type_scr1_lsu_cmd_sel_e        exu2lsu_cmd,
    input  logic [SCR1_XLEN-1:0]          exu2lsu_addr,
    input  logic [SCR1_XLEN-1:0]          exu2lsu_s_data,
    output logic                          lsu2exu_req_ack,
    output logic                          lsu2exu_rdy,
    output logic [SCR1_XLEN-1:0]          lsu2exu_l_data,
    output logic                          lsu2exu_exc,
    output type_scr1_exc_code_e           lsu2exu_exc_code,
    output logic                          lsu_busy,
    output logic                          lsu2dmem_req,
    output type_scr1_mem_cmd_e            lsu2dmem_cmd,
    output type_scr1_mem_width_e          lsu2dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0]   lsu2dmem_addr,
    output logic [DMEM_DWIDTH-1:0]        lsu2dmem_wdata,
    input  logic                          dmem2lsu_req_ack,
    input  logic [DMEM_DWIDTH-1:0]        dmem2lsu_rdata,
    input  type_scr1_mem_resp_e           dmem2lsu_resp
);

    localparam int unsigned OFFS_W = $clog2(DMEM_DWIDTH / 8);
    localparam int unsigned CNT_W  = $clog2(OUTST_DEPTH + 1);

    type_scr1_lsu_q_entry_s q_head;
    type_scr1_lsu_q_entry_s q_push_data;
    logic [CNT_W-1:0]       q_cnt;
    logic                   q_full;
    logic                   q_empty;
    logic                   q_push;
    logic                   q_pop;
    logic                   req_misalign;
    logic                   misalign_exc;
    logic                   resp_vld;
    logic                   resp_pop;
    logic                   tmo_fire;
    logic                   stray_resp;
    logic [63:0]            rdata_ext;

    assign req_misalign = scr1_lsu_misalign(exu2lsu_cmd, exu2lsu_addr[1:0]);
    // Misaligned requests wait for the queue to drain so exceptions stay in order.
    assign misalign_exc = exu2lsu_req & req_misalign & q_empty;
    assign lsu2dmem_req = exu2lsu_req & ~req_misalign & ~q_full;
    assign q_push       = lsu2dmem_req & dmem2lsu_req_ack;
    assign resp_vld     = (dmem2lsu_resp == SCR1_MEM_RESP_RDY_OK)
                        | (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER);

    assign q_push_data.cmd    = exu2lsu_cmd;
    assign q_push_data.offset = SCR1_LSU_OFFS_W'(exu2lsu_addr[OFFS_W-1:0]);

    scr1_lsu_cmd_queue #(
        .DEPTH (OUTST_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .cnt       (q_cnt),
        .full      (q_full),
        .empty     (q_empty)
    );

`ifdef SCR1_LSU_RESP_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(RESP_TIMEOUT + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stale_q, stale_d;
    logic             resp_drop;

    // Responses still owed for timed-out entries are swallowed before any real one.
    assign resp_drop  = resp_vld & (stale_q != '0);
    assign resp_pop   = resp_vld & ~resp_drop & ~q_empty;
    assign tmo_fire   = ~q_empty & ~resp_vld & (timer_q == TMR_W'(RESP_TIMEOUT - 1));
    assign stray_resp = resp_vld & q_empty & (stale_q == '0);

    always_comb begin
        timer_d = timer_q;
        stale_d = stale_q;
        if (q_empty || q_pop) begin
            timer_d = '0;
        end else if (!resp_vld) begin
            timer_d = timer_q + TMR_W'(1);
        end
        if (resp_drop) begin
            stale_d = stale_q - CNT_W'(1);
        end else if (tmo_fire && (stale_q != CNT_W'(OUTST_DEPTH))) begin
            stale_d = stale_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            stale_q <= '0;
        end else begin
            timer_q <= timer_d;
            stale_q <= stale_d;
        end
    end
`else
    assign resp_pop   = resp_vld & ~q_empty;
    assign tmo_fire   = 1'b0;
    assign stray_resp = resp_vld & q_empty;
`endif

    assign q_pop    = resp_pop | tmo_fire;
    assign lsu_busy = ~q_empty;

    generate
        if (DMEM_DWIDTH == 64) begin : g_rdata_w64
            assign rdata_ext = dmem2lsu_rdata;
        end else begin : g_rdata_w32
            assign rdata_ext = {32'h0, dmem2lsu_rdata};
        end
    endgenerate

    always_comb begin
        lsu2exu_req_ack  = q_push | misalign_exc;
        lsu2exu_rdy      = misalign_exc | resp_pop | tmo_fire;
        lsu2exu_exc      = 1'b0;
        lsu2exu_exc_code = SCR1_EXC_CODE_INSTR_MISALIGN;
        lsu2exu_l_data   = '0;
        if (misalign_exc) begin
            lsu2exu_exc      = 1'b1;
            lsu2exu_exc_code = scr1_lsu_is_store(exu2lsu_cmd) ? SCR1_EXC_CODE_ST_ADDR_MISALIGN
                                                              : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
        end else if (tmo_fire || (resp_pop && (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER))) begin
            lsu2exu_exc      = 1'b1;
            lsu2exu_exc_code = scr1_lsu_is_store(q_head.cmd) ? SCR1_EXC_CODE_ST_ACCESS_FAULT
                                                             : SCR1_EXC_CODE_LD_ACCESS_FAULT;
        end else if (resp_pop && scr1_lsu_is_load(q_head.cmd)) begin
            lsu2exu_l_data = scr1_lsu_ld_extract(rdata_ext, q_head.offset, q_head.cmd);
        end
    end

    always_comb begin
        lsu2dmem_cmd   = SCR1_MEM_CMD_RD;
        lsu2dmem_width = SCR1_MEM_WIDTH_BYTE;
        lsu2dmem_addr  = '0;
        lsu2dmem_wdata = '0;
        if (exu2lsu_req) begin
            lsu2dmem_addr = exu2lsu_addr;
            lsu2dmem_cmd  = scr1_lsu_is_store(exu2lsu_cmd) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
            case (exu2lsu_cmd)
                SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_SH:
                    lsu2dmem_width = SCR1_MEM_WIDTH_HWORD;
                SCR1_LSU_CMD_LW, SCR1_LSU_CMD_SW:
                    lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
                default:
                    lsu2dmem_width = SCR1_MEM_WIDTH_BYTE;
            endcase
            case (exu2lsu_cmd)
                SCR1_LSU_CMD_SB: lsu2dmem_wdata = {(DMEM_DWIDTH / 8){exu2lsu_s_data[7:0]}};
                SCR1_LSU_CMD_SH: lsu2dmem_wdata = {(DMEM_DWIDTH / 16){exu2lsu_s_data[15:0]}};
                SCR1_LSU_CMD_SW: lsu2dmem_wdata = {(DMEM_DWIDTH / 32){exu2lsu_s_data[31:0]}};
                default:         lsu2dmem_wdata = '0;
            endcase
        end
    end

    // Responses owed to transactions dropped by a reset are expected; any other
    // response arriving with nothing outstanding indicates a protocol error.
    logic [CNT_W-1:0] lost_q, lost_d;

    always_comb begin
        lost_d = lost_q;
        if (stray_resp && (lost_q != '0)) begin
            lost_d = lost_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (q_cnt != '0) begin
                lost_q <= q_cnt;
            end
        end else begin
            lost_q <= lost_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((DMEM_DWIDTH == 32) || (DMEM_DWIDTH == 64))
                else $error("scr1_pipe_lsu_mo: illegal DMEM_DWIDTH");
            assert ((OUTST_DEPTH >= 1) && (OUTST_DEPTH <= 4) && (RESP_TIMEOUT >= 1))
                else $error("scr1_pipe_lsu_mo: illegal OUTST_DEPTH or RESP_TIMEOUT");
            assert (!(stray_resp && (lost_q == '0)))
                else $error("scr1_pipe_lsu_mo: DMEM response with no outstanding transaction");
        end
    end

endmodule : scr1_pipe_lsu_mo

`default_nettype wire

// File: tb/tb_scr1_pipe_lsu_mo.sv
//==============================================================================
// Module      : tb_scr1_pipe_lsu_mo
// Description : Directed self-checking bench for scr1_pipe_lsu_mo with a
//               32-bit and a 64-bit DMEM instance.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_scr1_pipe_lsu_mo;
    import scr1_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 32-bit instance
    logic                   req, dack, req_ack, rdy, exc, busy, dreq;
    type_scr1_lsu_cmd_sel_e cmd;
    logic [31:0]            addr, sdata, rdata, ldata, daddr, wdata;
    type_scr1_mem_resp_e    resp;
    type_scr1_exc_code_e    code;
    type_scr1_mem_cmd_e     dcmd;
    type_scr1_mem_width_e   dwidth;

    // 64-bit instance
    logic                   req64, dack64, req_ack64, rdy64, exc64, busy64, dreq64;
    type_scr1_lsu_cmd_sel_e cmd64;
    logic [31:0]            addr64, sdata64, ldata64, daddr64;
    logic [63:0]            rdata64, wdata64;
    type_scr1_mem_resp_e    resp64;
    type_scr1_exc_code_e    code64;
    type_scr1_mem_cmd_e     dcmd64;
    type_scr1_mem_width_e   dwidth64;

    scr1_pipe_lsu_mo #(.DMEM_DWIDTH(32), .OUTST_DEPTH(2), .RESP_TIMEOUT(8)) u_dut32 (
        .clk(clk), .rst(rst),
        .exu2lsu_req(req), .exu2lsu_cmd(cmd), .exu2lsu_addr(addr), .exu2lsu_s_data(sdata),
        .lsu2exu_req_ack(req_ack), .lsu2exu_rdy(rdy), .lsu2exu_l_data(ldata),
        .lsu2exu_exc(exc), .lsu2exu_exc_code(code), .lsu_busy(busy),
        .lsu2dmem_req(dreq), .lsu2dmem_cmd(dcmd), .lsu2dmem_width(dwidth),
        .lsu2dmem_addr(daddr), .lsu2dmem_wdata(wdata),
        .dmem2lsu_req_ack(dack), .dmem2lsu_rdata(rdata), .dmem2lsu_resp(resp)
    );

    scr1_pipe_lsu_mo #(.DMEM_DWIDTH(64), .OUTST_DEPTH(2), .RESP_TIMEOUT(256)) u_dut64 (
        .clk(clk), .rst(rst),
        .exu2lsu_req(req64), .exu2lsu_cmd(cmd64), .exu2lsu_addr(addr64), .exu2lsu_s_data(sdata64),
        .lsu2exu_req_ack(req_ack64), .lsu2exu_rdy(rdy64), .lsu2exu_l_data(ldata64),
        .lsu2exu_exc(exc64), .lsu2exu_exc_code(code64), .lsu_busy(busy64),
        .lsu2dmem_req(dreq64), .lsu2dmem_cmd(dcmd64), .lsu2dmem_width(dwidth64),
        .lsu2dmem_addr(daddr64), .lsu2dmem_wdata(wdata64),
        .dmem2lsu_req_ack(dack64), .dmem2lsu_rdata(rdata64), .dmem2lsu_resp(resp64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive32(input logic r, input type_scr1_lsu_cmd_sel_e c, input logic [31:0] a,
                           input logic [31:0] d, input logic ack, input type_scr1_mem_resp_e rs,
                           input logic [31:0] rd);
        req = r; cmd = c; addr = a; sdata = d; dack = ack; resp = rs; rdata = rd;
    endtask

    task automatic drive64(input logic r, input type_scr1_lsu_cmd_sel_e c, input logic [31:0] a,
                           input logic [31:0] d, input logic ack, input type_scr1_mem_resp_e rs,
                           input logic [63:0] rd);
        req64 = r; cmd64 = c; addr64 = a; sdata64 = d; dack64 = ack; resp64 = rs; rdata64 = rd;
    endtask

    task automatic idle32();
        drive32(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
    endtask

    task automatic test_reset();
        idle32();
        drive64(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sample();
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL reset_rdy: got %0b exp 0", rdy); end
        checks++; if (req_ack !== 1'b0) begin errors++; $display("FAIL reset_req_ack: got %0b exp 0", req_ack); end
        checks++; if (dreq !== 1'b0)    begin errors++; $display("FAIL reset_dmem_req: got %0b exp 0", dreq); end
        checks++; if (ldata !== 32'h0)  begin errors++; $display("FAIL reset_l_data: got %h exp 0", ldata); end
        checks++; if (busy64 !== 1'b0)  begin errors++; $display("FAIL reset_busy64: got %0b exp 0", busy64); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h100, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (dreq !== 1'b1 || req_ack !== 1'b1)
            begin errors++; $display("FAIL b2b_lw_issue: got req=%0b ack=%0b exp 1/1", dreq, req_ack); end
        checks++; if (dcmd !== SCR1_MEM_CMD_RD || dwidth !== SCR1_MEM_WIDTH_WORD || daddr !== 32'h100)
            begin errors++; $display("FAIL b2b_lw_fields: got cmd=%0d w=%0d a=%h exp 0/2/100", dcmd, dwidth, daddr); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_SW, 32'h104, 32'hDEADBEEF, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (dreq !== 1'b1 || req_ack !== 1'b1 || dcmd !== SCR1_MEM_CMD_WR)
            begin errors++; $display("FAIL b2b_sw_issue: got req=%0b ack=%0b cmd=%0d exp 1/1/1", dreq, req_ack, dcmd); end
        checks++; if (wdata !== 32'hDEADBEEF || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_sw_wdata: got %h busy=%0b exp deadbeef/1", wdata, busy); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h108, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (dreq !== 1'b0 || req_ack !== 1'b0)
            begin errors++; $display("FAIL b2b_full_stall: got req=%0b ack=%0b exp 0/0", dreq, req_ack); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h108, 32'h0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'h12345678);
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b0 || ldata !== 32'h12345678)
            begin errors++; $display("FAIL b2b_resp1: got rdy=%0b exc=%0b d=%h exp 1/0/12345678", rdy, exc, ldata); end
        checks++; if (dreq !== 1'b0 || req_ack !== 1'b0)
            begin errors++; $display("FAIL b2b_no_bypass: got req=%0b ack=%0b exp 0/0", dreq, req_ack); end
        tick();
        drive32(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'hFFFFFFFF);
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b0 || ldata !== 32'h0)
            begin errors++; $display("FAIL b2b_resp2_store: got rdy=%0b exc=%0b d=%h exp 1/0/0", rdy, exc, ldata); end
        tick();
        idle32();
        sample();
        checks++; if (busy !== 1'b0 || rdy !== 1'b0)
            begin errors++; $display("FAIL b2b_drained: got busy=%0b rdy=%0b exp 0/0", busy, rdy); end
        tick();
    endtask

    task automatic test_lanes_64();
        drive64(1'b1, SCR1_LSU_CMD_LB, 32'h1005, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        sample();
        checks++; if (dreq64 !== 1'b1 || dwidth64 !== SCR1_MEM_WIDTH_BYTE)
            begin errors++; $display("FAIL lane_lb_issue: got req=%0b w=%0d exp 1/0", dreq64, dwidth64); end
        tick();
        drive64(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 64'h0000_80FF_0000_0000);
        sample();
        checks++; if (rdy64 !== 1'b1 || ldata64 !== 32'hFFFF_FF80)
            begin errors++; $display("FAIL lane_lb_data: got rdy=%0b d=%h exp 1/ffffff80", rdy64, ldata64); end
        tick();
        drive64(1'b1, SCR1_LSU_CMD_LBU, 32'h1005, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        tick();
        drive64(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 64'h0000_80FF_0000_0000);
        sample();
        checks++; if (rdy64 !== 1'b1 || ldata64 !== 32'h0000_0080)
            begin errors++; $display("FAIL lane_lbu_data: got rdy=%0b d=%h exp 1/00000080", rdy64, ldata64); end
        tick();
        drive64(1'b1, SCR1_LSU_CMD_LH, 32'h1006, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        tick();
        drive64(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 64'h8001_0000_0000_0000);
        sample();
        checks++; if (ldata64 !== 32'hFFFF_8001)
            begin errors++; $display("FAIL lane_lh_data: got %h exp ffff8001", ldata64); end
        tick();
        drive64(1'b1, SCR1_LSU_CMD_SH, 32'h1002, 32'hAAAA1234, 1'b1, SCR1_MEM_RESP_NOTRDY, 64'h0);
        sample();
        checks++; if (wdata64 !== 64'h1234_1234_1234_1234 || dwidth64 !== SCR1_MEM_WIDTH_HWORD)
            begin errors++; $display("FAIL lane_sh_wdata: got %h w=%0d exp 1234123412341234/1", wdata64, dwidth64); end
        tick();
        drive64(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 64'hFFFF_FFFF_FFFF_FFFF);
        sample();
        checks++; if (rdy64 !== 1'b1 || ldata64 !== 32'h0)
            begin errors++; $display("FAIL lane_sh_resp: got rdy=%0b d=%h exp 1/0", rdy64, ldata64); end
        tick();
        drive64(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_NOTRDY, 64'h0);
        tick();
    endtask

    task automatic test_misalign();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h200, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LH, 32'h101, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (req_ack !== 1'b0 || dreq !== 1'b0 || rdy !== 1'b0)
            begin errors++; $display("FAIL mis_stall: got ack=%0b req=%0b rdy=%0b exp 0/0/0", req_ack, dreq, rdy); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LH, 32'h101, 32'h0, 1'b1, SCR1_MEM_RESP_RDY_OK, 32'hCAFE0001);
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b0 || req_ack !== 1'b0 || ldata !== 32'hCAFE0001)
            begin errors++; $display("FAIL mis_pending_resp: got rdy=%0b exc=%0b ack=%0b d=%h exp 1/0/0/cafe0001", rdy, exc, req_ack, ldata); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LH, 32'h101, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b1 || req_ack !== 1'b1 || dreq !== 1'b0)
            begin errors++; $display("FAIL mis_lh_exc: got rdy=%0b exc=%0b ack=%0b req=%0b exp 1/1/1/0", rdy, exc, req_ack, dreq); end
        checks++; if (code !== SCR1_EXC_CODE_LD_ADDR_MISALIGN)
            begin errors++; $display("FAIL mis_lh_code: got %0d exp 4", code); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_SW, 32'h102, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (exc !== 1'b1 || code !== SCR1_EXC_CODE_ST_ADDR_MISALIGN || dreq !== 1'b0)
            begin errors++; $display("FAIL mis_sw_code: got exc=%0b code=%0d req=%0b exp 1/6/0", exc, code, dreq); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_SB, 32'h103, 32'h0000005A, 1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        sample();
        checks++; if (dreq !== 1'b1 || exc !== 1'b0 || wdata !== 32'h5A5A5A5A || req_ack !== 1'b0)
            begin errors++; $display("FAIL mis_sb_ok: got req=%0b exc=%0b wd=%h ack=%0b exp 1/0/5a5a5a5a/0", dreq, exc, wdata, req_ack); end
        tick();
        idle32();
        sample();
        checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL mis_idle_busy: got %0b exp 0", busy); end
        tick();
    endtask

    task automatic test_err_overlap();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h300, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();
        drive32(1'b1, SCR1_LSU_CMD_SW, 32'h304, 32'h11223344, 1'b1, SCR1_MEM_RESP_RDY_ER, 32'h0);
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b1 || code !== SCR1_EXC_CODE_LD_ACCESS_FAULT)
            begin errors++; $display("FAIL ovl_ld_fault: got rdy=%0b exc=%0b code=%0d exp 1/1/5", rdy, exc, code); end
        checks++; if (req_ack !== 1'b1 || dreq !== 1'b1)
            begin errors++; $display("FAIL ovl_sw_issue: got ack=%0b req=%0b exp 1/1", req_ack, dreq); end
        tick();
        idle32();
        sample();
        checks++; if (busy !== 1'b1 || rdy !== 1'b0)
            begin errors++; $display("FAIL ovl_sw_retained: got busy=%0b rdy=%0b exp 1/0", busy, rdy); end
        tick();
        drive32(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_ER, 32'h0);
        sample();
        checks++; if (exc !== 1'b1 || code !== SCR1_EXC_CODE_ST_ACCESS_FAULT)
            begin errors++; $display("FAIL ovl_st_fault: got exc=%0b code=%0d exp 1/7", exc, code); end
        tick();
        idle32();
        sample();
        checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL ovl_drained: got %0b exp 0", busy); end
        tick();
    endtask

    task automatic test_reset_midflight();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h400, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h404, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();
        idle32();
        sample();
        checks++; if (busy !== 1'b1)
            begin errors++; $display("FAIL rstmid_busy_before: got %0b exp 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_busy_after: got %0b exp 0", busy); end
        tick();
        drive32(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'h55AA55AA);
        sample();
        checks++; if (rdy !== 1'b0 || ldata !== 32'h0)
            begin errors++; $display("FAIL rstmid_late_resp: got rdy=%0b d=%h exp 0/0", rdy, ldata); end
        tick();
        idle32();
        tick();
    endtask

`ifdef SCR1_LSU_RESP_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        early = 0;
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h500, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();
        idle32();
        for (int i = 0; i < 7; i++) begin
            sample();
            if (rdy !== 1'b0) early++;
            tick();
        end
        checks++; if (early != 0)
            begin errors++; $display("FAIL tmo_early: got %0d early rdy cycles exp 0", early); end
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b1 || code !== SCR1_EXC_CODE_LD_ACCESS_FAULT)
            begin errors++; $display("FAIL tmo_fire: got rdy=%0b exc=%0b code=%0d exp 1/1/5", rdy, exc, code); end
        tick();
        drive32(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'h0BADF00D);
        sample();
        checks++; if (rdy !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL tmo_late_drop: got rdy=%0b busy=%0b exp 0/0", rdy, busy); end
        tick();
        drive32(1'b1, SCR1_LSU_CMD_LW, 32'h504, 32'h0, 1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        tick();
        drive32(1'b0, SCR1_LSU_CMD_NONE, 32'h0, 32'h0, 1'b0, SCR1_MEM_RESP_RDY_OK, 32'h600DF00D);
        sample();
        checks++; if (rdy !== 1'b1 || exc !== 1'b0 || ldata !== 32'h600DF00D)
            begin errors++; $display("FAIL tmo_stale_cleared: got rdy=%0b exc=%0b d=%h exp 1/0/600df00d", rdy, exc, ldata); end
        tick();
        idle32();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_lanes_64();
        test_misalign();
        test_err_overlap();
        test_reset_midflight();
`ifdef SCR1_LSU_RESP_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scr1_pipe_lsu_mo

`default_nettype wire
